// File: rtl/cmd_pkg.sv
// Shared constants and type decoding for the command frame parser.
// Frame layout: EB 90 <type> <payload...> <checksum>.
package cmd_pkg;

    localparam int MAX_LEN = 53;
    localparam int ADDR_W  = 6;

    localparam logic [7:0] SYNC_BYTE0 = 8'hEB;
    localparam logic [7:0] SYNC_BYTE1 = 8'h90;

    localparam logic [7:0] TYPE_TC = 8'h01;
    localparam logic [7:0] TYPE_HK = 8'h02;
    localparam logic [7:0] TYPE_SD = 8'h03;
    localparam logic [7:0] TYPE_DI = 8'h04;
    localparam logic [7:0] TYPE_PF = 8'h05;

    localparam logic [ADDR_W-1:0] LEN_TC = 6'd13;
    localparam logic [ADDR_W-1:0] LEN_HK = 6'd9;
    localparam logic [ADDR_W-1:0] LEN_SD = 6'd9;
    localparam logic [ADDR_W-1:0] LEN_DI = 6'd25;
    localparam logic [ADDR_W-1:0] LEN_PF = 6'd53;

    localparam int BIT_TC = 0;
    localparam int BIT_HK = 1;
    localparam int BIT_SD = 2;
    localparam int BIT_DI = 3;
    localparam int BIT_PF = 4;

    localparam int ERR_CHKSUM  = 0;
    localparam int ERR_TYPE    = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_DROP    = 3;

    typedef enum logic [2:0] {IDLE, HDR2, TYPE, BODY, DRAIN} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] len;
        logic [4:0]        sel;
    } type_info_t;

    // Unknown codes come back with valid=0 so the caller can flag them.
    function automatic type_info_t decode_type(input logic [7:0] code);
        type_info_t info;
        info = '0;
        case (code)
            TYPE_TC: begin info.valid = 1'b1; info.len = LEN_TC; info.sel = 5'b00001 << BIT_TC; end
            TYPE_HK: begin info.valid = 1'b1; info.len = LEN_HK; info.sel = 5'b00001 << BIT_HK; end
            TYPE_SD: begin info.valid = 1'b1; info.len = LEN_SD; info.sel = 5'b00001 << BIT_SD; end
            TYPE_DI: begin info.valid = 1'b1; info.len = LEN_DI; info.sel = 5'b00001 << BIT_DI; end
            TYPE_PF: begin info.valid = 1'b1; info.len = LEN_PF; info.sel = 5'b00001 << BIT_PF; end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/cmd_frame_buf.sv
// Frame storage: one write port, one combinational read port.
module cmd_frame_buf
    import cmd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [0:MAX_LEN-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_frame_parser.sv
// Hunts for the EB 90 sync, validates type and checksum, then replays the
// whole frame (header included) into the selected downstream command FIFO.
module cmd_frame_parser
    import cmd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       full,
    output logic [4:0] cmd,
    output logic       wen,
    output logic [7:0] dout,
    output logic       busy,
    output logic [3:0] err
);

    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_len, w_len_n;
    logic [4:0]        r_cmd, w_cmd_n;
    logic [ADDR_W-1:0] r_idx, w_idx_n;
    logic [7:0]        r_sum, w_sum_n;
    logic [15:0]       r_gap;
    logic [3:0]        r_err, w_err_n;
    logic              w_buf_we;
    logic [ADDR_W-1:0] w_buf_waddr;
    logic [7:0]        w_buf_rdata;
    type_info_t        w_info;
    logic              w_gap_hit;
    logic              w_last;

    assign w_info    = decode_type(rx_data);
    assign w_gap_hit = !rx_valid && (r_gap >= TIMEOUT - 16'd1);
    assign w_last    = (r_idx == r_len - ADDR_W'(1));

    cmd_frame_buf u_buf (
        .i_clk   (clk),
        .i_we    (w_buf_we),
        .i_waddr (w_buf_waddr),
        .i_wdata (rx_data),
        .i_raddr (r_idx),
        .o_rdata (w_buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cmd   <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_gap   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_n;
            r_len   <= w_len_n;
            r_cmd   <= w_cmd_n;
            r_idx   <= w_idx_n;
            r_sum   <= w_sum_n;
            r_err   <= w_err_n;
            if (rx_valid) begin
                r_gap <= '0;
            end else if (r_gap != 16'hFFFF) begin
                r_gap <= r_gap + 16'd1;
            end
        end
    end

    // r_idx doubles as the write pointer while receiving and the read pointer while draining.
    always_comb begin
        w_state_n   = r_state;
        w_len_n     = r_len;
        w_cmd_n     = r_cmd;
        w_idx_n     = r_idx;
        w_sum_n     = r_sum;
        w_err_n     = '0;
        w_buf_we    = 1'b0;
        w_buf_waddr = r_idx;
        case (r_state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE0) begin
                    w_state_n   = HDR2;
                    w_buf_we    = 1'b1;
                    w_buf_waddr = '0;
                end
            end
            HDR2: begin
                if (rx_valid) begin
                    if (rx_data == SYNC_BYTE1) begin
                        w_state_n   = TYPE;
                        w_buf_we    = 1'b1;
                        w_buf_waddr = ADDR_W'(1);
                    end else if (rx_data == SYNC_BYTE0) begin
                        w_buf_we    = 1'b1;
                        w_buf_waddr = '0;
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (w_gap_hit) begin
                    w_state_n            = IDLE;
                    w_err_n[ERR_TIMEOUT] = 1'b1;
                end
            end
            TYPE: begin
                if (rx_valid) begin
                    if (w_info.valid) begin
                        w_state_n   = BODY;
                        w_len_n     = w_info.len;
                        w_cmd_n     = w_info.sel;
                        w_sum_n     = rx_data;
                        w_idx_n     = ADDR_W'(3);
                        w_buf_we    = 1'b1;
                        w_buf_waddr = ADDR_W'(2);
                    end else begin
                        w_state_n         = IDLE;
                        w_err_n[ERR_TYPE] = 1'b1;
                    end
                end else if (w_gap_hit) begin
                    w_state_n            = IDLE;
                    w_err_n[ERR_TIMEOUT] = 1'b1;
                end
            end
            BODY: begin
                if (rx_valid) begin
                    w_buf_we = 1'b1;
                    if (w_last) begin
                        if (rx_data == r_sum) begin
                            w_state_n = DRAIN;
                            w_idx_n   = '0;
                        end else begin
                            w_state_n           = IDLE;
                            w_err_n[ERR_CHKSUM] = 1'b1;
                        end
                    end else begin
                        w_sum_n = r_sum + rx_data;
                        w_idx_n = r_idx + ADDR_W'(1);
                    end
                end else if (w_gap_hit) begin
                    w_state_n            = IDLE;
                    w_err_n[ERR_TIMEOUT] = 1'b1;
                end
            end
            DRAIN: begin
                if (rx_valid) begin
                    w_err_n[ERR_DROP] = 1'b1;
                end
                if (!full) begin
                    if (w_last) begin
                        w_state_n = IDLE;
                        w_idx_n   = '0;
                    end else begin
                        w_idx_n = r_idx + ADDR_W'(1);
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign wen  = (r_state == DRAIN) && !full;
    assign cmd  = (r_state == DRAIN) ? r_cmd : 5'b0;
    assign dout = (r_state == DRAIN) ? w_buf_rdata : 8'h00;
    assign busy = (r_state != IDLE);
    assign err  = r_err;

endmodule
